// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch front end that consumes the program counter. Whenever buffer space
// allows, it samples `pc` as the next fetch address. Otherwise it raises
// `pc_hold` so the PC keeps its value. For each sampled address it runs one
// request/acknowledge transaction to instruction memory. Returned bytes,
// tagged with their address, go into a small prefetch FIFO. The decoder
// drains that FIFO through a valid/ready handshake. A `flush` (taken jump)
// discards the buffered entries and any in-flight fetch.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   pc           current PC from the program counter
//   pc_hold      1 = address not captured this cycle, PC must hold
//   flush        discard FIFO contents and the in-flight fetch
//   imem_req     memory request, held until acknowledged
//   imem_addr    request address, stable while imem_req = 1
//   imem_ack     memory returns data this cycle
//   imem_rdata   instruction byte, valid with imem_ack
//   instr_valid  FIFO head valid
//   instr        FIFO head instruction
//   instr_pc     address of the FIFO head
//   instr_ready  decoder accepts the head when instr_valid = 1
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_hold,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Two extra bits so both count (0..DEPTH) and count+1 fit without wrapping.
    localparam int CNT_W = PTR_W + 2;
    localparam int ENT_W = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n;
    logic [ADDR_W-1:0]   addr_r;
    logic [ENT_W-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_n;
    logic [PTR_W-1:0]    wr_ptr_n;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_n;
    logic [CNT_W-1:0]    cnt_pop_s;
    logic                pop_s;
    logic                push_s;
    logic                capture_s;
    logic                req_s;
    logic [ENT_W-1:0]    push_entry_s;
    logic [ENT_W-1:0]    head_n;
    logic                instr_valid_r;
    logic [DATA_W-1:0]   instr_r;
    logic [ADDR_W-1:0]   instr_pc_r;

    // Handshake qualifiers. A flush overrides any pop or push in the same cycle.
    assign pop_s        = instr_valid_r & instr_ready & ~flush;
    assign push_s       = (state_r == ST_REQ) & imem_ack & ~flush;
    assign cnt_pop_s    = count_r - CNT_W'(pop_s);
    assign push_entry_s = {addr_r, imem_rdata};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next state. A request is never withdrawn: a flush while waiting
    // parks in DROP until the memory acknowledges.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    state_n = ST_REQ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (capture_s) begin
                        state_n = ST_REQ;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (flush) begin
                    state_n = ST_DROP;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DROP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM outputs. Capture needs a free slot for the fetch it launches. In REQ
    // the slot must remain after this cycle's push, which allows back-to-back
    // fetches while the decoder drains.
    always_comb begin
        capture_s = 1'b0;
        req_s     = 1'b0;
        if (!rst_n) begin
            capture_s = 1'b0;
            req_s     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_s = 1'b0;
                    if (!flush && (cnt_pop_s < DEPTH_C)) begin
                        capture_s = 1'b1;
                    end else begin
                        capture_s = 1'b0;
                    end
                end
                ST_REQ: begin
                    req_s = 1'b1;
                    if (imem_ack && !flush && ((cnt_pop_s + ONE_C) < DEPTH_C)) begin
                        capture_s = 1'b1;
                    end else begin
                        capture_s = 1'b0;
                    end
                end
                ST_DROP: begin
                    req_s     = 1'b1;
                    capture_s = 1'b0;
                end
                default: begin
                    req_s     = 1'b0;
                    capture_s = 1'b0;
                end
            endcase
        end
    end

    // Fetch address register. It changes only when a new PC is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (capture_s) begin
            addr_r <= pc;
        end else begin
            addr_r <= addr_r;
        end
    end

    // FIFO pointer and occupancy update. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_comb begin
        rd_ptr_n = rd_ptr_r;
        wr_ptr_n = wr_ptr_r;
        count_n  = count_r;
        if (flush) begin
            rd_ptr_n = {PTR_W{1'b0}};
            wr_ptr_n = {PTR_W{1'b0}};
            count_n  = {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_n = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_n = rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_n = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_n = wr_ptr_r;
            end
            count_n = cnt_pop_s + CNT_W'(push_s);
        end
    end

    // Next head entry. If the new head is the slot being written this cycle,
    // forward the incoming data so an empty FIFO shows it one cycle after the ack.
    always_comb begin
        head_n = mem_r[rd_ptr_n];
        if (push_s && (rd_ptr_n == wr_ptr_r)) begin
            head_n = push_entry_s;
        end else begin
            head_n = mem_r[rd_ptr_n];
        end
    end

    // FIFO pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_n;
            wr_ptr_r <= wr_ptr_n;
            count_r  <= count_n;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Registered FIFO head presented to the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_r <= 1'b0;
            instr_r       <= {DATA_W{1'b0}};
            instr_pc_r    <= {ADDR_W{1'b0}};
        end else begin
            instr_valid_r           <= (count_n != {CNT_W{1'b0}});
            {instr_pc_r, instr_r}   <= head_n;
        end
    end

    assign pc_hold     = ~capture_s;
    assign imem_req    = req_s;
    assign imem_addr   = addr_r;
    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. The stimulus thread drives pc, ack,
// rdata, ready and flush once per cycle. Each time it acknowledges a fetch
// that should reach the FIFO, it pushes the expected {addr, data} pair into
// a queue. A forked monitor pops and compares that queue whenever the
// decoder handshake completes. The monitor empties the queue on a flush.
// Cycle-specific control outputs are checked directly at the falling edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] pc;
    logic              pc_hold;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .pc_hold     (pc_hold),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares every accepted head against the queue.
    task automatic monitor_loop();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && flush) begin
                exp_q.delete();
            end else if (rst_n && instr_valid && instr_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc=0x%0h instr=0x%0h expected nothing", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_head", 32'({instr_pc, instr}), 32'(e));
                end
            end
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for the falling edge.
    task automatic next(input logic [7:0] p, input logic ack, input logic [7:0] rd,
                        input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        pc          = p;
        imem_ack    = ack;
        imem_rdata  = rd;
        instr_ready = rdy;
        flush       = fl;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] kb;
        rst_n       = 1'b0;
        pc          = 8'h00;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 8'h00;
        instr_ready = 1'b0;

        fork
            monitor_loop();
        join_none

        // Reset state.
        #2;
        chk("rst_pc_hold",     32'(pc_hold),     32'h1);
        chk("rst_imem_req",    32'(imem_req),    32'h0);
        chk("rst_imem_addr",   32'(imem_addr),   32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr",       32'(instr),       32'h0);
        chk("rst_instr_pc",    32'(instr_pc),    32'h0);
        @(negedge clk);

        // Test 1: single fetch with a one-cycle memory wait.
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        pc          = 8'h01;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("t1_capture_hold", 32'(pc_hold), 32'h0);
        next(8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_req",        32'(imem_req),    32'h1);
        chk("t1_addr",       32'(imem_addr),   32'h01);
        chk("t1_wait_hold",  32'(pc_hold),     32'h1);
        chk("t1_not_valid",  32'(instr_valid), 32'h0);
        next(8'h10, 1'b1, 8'hA5, 1'b1, 1'b0);
        exp_q.push_back({8'h01, 8'hA5});
        chk("t1_ack_hold",   32'(pc_hold),     32'h0);
        next(8'h11, 1'b1, 8'h3C, 1'b1, 1'b0);
        exp_q.push_back({8'h10, 8'h3C});
        chk("t1_valid",      32'(instr_valid), 32'h1);
        chk("t1_instr",      32'(instr),       32'hA5);
        chk("t1_instr_pc",   32'(instr_pc),    32'h01);

        // Test 2: decoder stalls, FIFO fills, then drains in order.
        chk("t2_addr10",     32'(imem_addr),   32'h10);
        chk("t2_hold0",      32'(pc_hold),     32'h0);
        next(8'h12, 1'b1, 8'h4D, 1'b0, 1'b0);
        exp_q.push_back({8'h11, 8'h4D});
        chk("t2_addr11",     32'(imem_addr),   32'h11);
        chk("t2_full_hold",  32'(pc_hold),     32'h1);
        chk("t2_head_3c",    32'(instr),       32'h3C);
        next(8'h12, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_full_hold2", 32'(pc_hold),     32'h1);
        chk("t2_no_req",     32'(imem_req),    32'h0);
        chk("t2_valid",      32'(instr_valid), 32'h1);
        next(8'h12, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_stall_instr", 32'(instr),      32'h3C);
        chk("t2_stall_pc",   32'(instr_pc),    32'h10);
        chk("t2_no_req2",    32'(imem_req),    32'h0);
        next(8'h20, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_resume",     32'(pc_hold),     32'h0);

        // Test 3: flush while a request is outstanding; the late data is dropped.
        next(8'h20, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_req",        32'(imem_req),    32'h1);
        chk("t3_addr",       32'(imem_addr),   32'h20);
        chk("t3_head_4d",    32'(instr),       32'h4D);
        next(8'h20, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("t3_flush_req",  32'(imem_req),    32'h1);
        chk("t3_flush_hold", 32'(pc_hold),     32'h1);
        next(8'h20, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_drop_req",   32'(imem_req),    32'h1);
        chk("t3_drop_hold",  32'(pc_hold),     32'h1);
        chk("t3_drop_valid", 32'(instr_valid), 32'h0);
        next(8'h30, 1'b1, 8'hFF, 1'b1, 1'b0);
        chk("t3_ack_req",    32'(imem_req),    32'h1);
        chk("t3_ack_hold",   32'(pc_hold),     32'h1);
        next(8'h30, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_idle_req",   32'(imem_req),    32'h0);
        chk("t3_recapture",  32'(pc_hold),     32'h0);
        chk("t3_ff_dropped", 32'(instr_valid), 32'h0);

        // Test 4: flush coincides with an ack while one entry is buffered.
        next(8'h31, 1'b1, 8'h5A, 1'b0, 1'b0);
        exp_q.push_back({8'h30, 8'h5A});
        chk("t4_addr",       32'(imem_addr),   32'h30);
        next(8'h31, 1'b1, 8'h77, 1'b0, 1'b1);
        chk("t4_one_entry",  32'(instr_valid), 32'h1);
        chk("t4_head_5a",    32'(instr),       32'h5A);
        chk("t4_no_capture", 32'(pc_hold),     32'h1);
        next(8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_cleared",    32'(instr_valid), 32'h0);
        chk("t4_idle",       32'(imem_req),    32'h0);
        chk("t4_capture",    32'(pc_hold),     32'h0);

        // Test 5: memory acks every cycle while the decoder always accepts.
        for (int k = 0; k < 6; k++) begin
            kb = 8'(k);
            next((k == 5) ? 8'h40 : kb + 8'h01, 1'b1, 8'hD0 + kb, 1'b1, 1'b0);
            exp_q.push_back({kb, 8'hD0 + kb});
            chk("t5_hold",  32'(pc_hold),   32'h0);
            chk("t5_addr",  32'(imem_addr), 32'(kb));
            if (k > 0) begin
                chk("t5_valid",    32'(instr_valid), 32'h1);
                chk("t5_instr_pc", 32'(instr_pc),    32'(kb - 8'h01));
            end
        end

        // Test 6: asynchronous reset mid-request with the FIFO non-empty.
        next(8'h40, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_pre_valid",  32'(instr_valid), 32'h1);
        chk("t6_pre_pc",     32'(instr_pc),    32'h05);
        chk("t6_pre_instr",  32'(instr),       32'hD5);
        chk("t6_pre_req",    32'(imem_req),    32'h1);
        chk("t6_pre_addr",   32'(imem_addr),   32'h40);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_req",        32'(imem_req),    32'h0);
        chk("t6_valid",      32'(instr_valid), 32'h0);
        chk("t6_instr",      32'(instr),       32'h0);
        chk("t6_instr_pc",   32'(instr_pc),    32'h0);
        chk("t6_addr",       32'(imem_addr),   32'h0);
        chk("t6_hold",       32'(pc_hold),     32'h1);

        // Heads accepted: A5, 3C, 4D and D0..D4.
        chk("sb_pop_count",  32'(pops),        32'd8);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
